// File: rtl/vga_timing_gen_if.sv
//------------------------------------------------------------------------------
// Module      : vga_timing_gen_if
// Description : Bundle of timing programming inputs, run enable and raster
//               outputs of the VGA timing generator. The generator uses the
//               master modport. Whatever programs and consumes it uses slave.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface vga_timing_gen_if #(
    parameter int CW = 12
);
    logic          EN;
    logic [CW-1:0] H_SYNC_END;
    logic [CW-1:0] H_ACT_START;
    logic [CW-1:0] H_ACT_END;
    logic [CW-1:0] H_TOTAL;
    logic [CW-1:0] V_SYNC_END;
    logic [CW-1:0] V_ACT_START;
    logic [CW-1:0] V_ACT_END;
    logic [CW-1:0] V_TOTAL;
    logic          HSYNC;
    logic          VSYNC;
    logic          DE;
    logic [CW-1:0] X;
    logic [CW-1:0] Y;
    logic          PIX_TICK;
    logic          LINE_START;
    logic          FRAME_START;

    modport master (
        input  EN, H_SYNC_END, H_ACT_START, H_ACT_END, H_TOTAL,
               V_SYNC_END, V_ACT_START, V_ACT_END, V_TOTAL,
        output HSYNC, VSYNC, DE, X, Y, PIX_TICK, LINE_START, FRAME_START
    );

    modport slave (
        output EN, H_SYNC_END, H_ACT_START, H_ACT_END, H_TOTAL,
               V_SYNC_END, V_ACT_START, V_ACT_END, V_TOTAL,
        input  HSYNC, VSYNC, DE, X, Y, PIX_TICK, LINE_START, FRAME_START
    );
endinterface

`default_nettype wire

// File: rtl/vga_timing_gen.sv
//------------------------------------------------------------------------------
// Module      : vga_timing_gen
// Description : Runtime-programmable VGA raster timing generator. A prescaler
//               derives the pixel tick from CLK. H/V counters are decoded into
//               sync, data enable, active-area coordinates and line/frame
//               strobes. All outputs are registered one CLK after the counters.
//               Optional macro VGA_SHADOW_EN: the timing inputs are latched
//               per frame so that mid-frame changes cannot tear a frame.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_timing_gen #(
    parameter int CW     = 12,
    parameter int DIV    = 2,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    vga_timing_gen_if.master bus
);

    localparam int            PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);

    logic [PW-1:0] pcnt;
    logic [CW-1:0] hcnt;
    logic [CW-1:0] vcnt;

    logic [CW-1:0] h_sync_end, h_act_start, h_act_end, h_total;
    logic [CW-1:0] v_sync_end, v_act_start, v_act_end, v_total;

    logic tick;
    logic h_wrap;
    logic v_wrap;

    assign tick   = bus.EN && (pcnt == PCNT_LAST);
    // >= rather than == so that lowering a TOTAL below the live count wraps at once
    assign h_wrap = (hcnt >= h_total);
    assign v_wrap = (vcnt >= v_total);

`ifdef VGA_SHADOW_EN
    logic          shadow_valid;
    logic [CW-1:0] sh_h_sync_end, sh_h_act_start, sh_h_act_end, sh_h_total;
    logic [CW-1:0] sh_v_sync_end, sh_v_act_start, sh_v_act_end, sh_v_total;

    // Latch the timing set after reset release and then only on the frame-ending tick
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shadow_valid   <= 1'b0;
            sh_h_sync_end  <= '0;
            sh_h_act_start <= '0;
            sh_h_act_end   <= '0;
            sh_h_total     <= '0;
            sh_v_sync_end  <= '0;
            sh_v_act_start <= '0;
            sh_v_act_end   <= '0;
            sh_v_total     <= '0;
        end else if (!shadow_valid || (tick && h_wrap && v_wrap)) begin
            shadow_valid   <= 1'b1;
            sh_h_sync_end  <= bus.H_SYNC_END;
            sh_h_act_start <= bus.H_ACT_START;
            sh_h_act_end   <= bus.H_ACT_END;
            sh_h_total     <= bus.H_TOTAL;
            sh_v_sync_end  <= bus.V_SYNC_END;
            sh_v_act_start <= bus.V_ACT_START;
            sh_v_act_end   <= bus.V_ACT_END;
            sh_v_total     <= bus.V_TOTAL;
        end
    end

    // On the very first CLK after reset the shadows are still zero. The
    // inputs being captured on that edge stand in for them so that this
    // edge does not see a zero-length line.
    assign h_sync_end  = shadow_valid ? sh_h_sync_end  : bus.H_SYNC_END;
    assign h_act_start = shadow_valid ? sh_h_act_start : bus.H_ACT_START;
    assign h_act_end   = shadow_valid ? sh_h_act_end   : bus.H_ACT_END;
    assign h_total     = shadow_valid ? sh_h_total     : bus.H_TOTAL;
    assign v_sync_end  = shadow_valid ? sh_v_sync_end  : bus.V_SYNC_END;
    assign v_act_start = shadow_valid ? sh_v_act_start : bus.V_ACT_START;
    assign v_act_end   = shadow_valid ? sh_v_act_end   : bus.V_ACT_END;
    assign v_total     = shadow_valid ? sh_v_total     : bus.V_TOTAL;
`else
    assign h_sync_end  = bus.H_SYNC_END;
    assign h_act_start = bus.H_ACT_START;
    assign h_act_end   = bus.H_ACT_END;
    assign h_total     = bus.H_TOTAL;
    assign v_sync_end  = bus.V_SYNC_END;
    assign v_act_start = bus.V_ACT_START;
    assign v_act_end   = bus.V_ACT_END;
    assign v_total     = bus.V_TOTAL;
`endif

    // Decode of the current counter state. An empty range never matches.
    logic          hs_act, vs_act, h_de, v_de, de;
    logic [CW-1:0] x_nxt, y_nxt;

    assign hs_act = (hcnt < h_sync_end);
    assign vs_act = (vcnt < v_sync_end);
    assign h_de   = (hcnt >= h_act_start) && (hcnt < h_act_end);
    assign v_de   = (vcnt >= v_act_start) && (vcnt < v_act_end);
    assign de     = h_de && v_de;
    assign x_nxt  = de ? (hcnt - h_act_start) : '0;
    assign y_nxt  = de ? (vcnt - v_act_start) : '0;

    // Registered outputs
    logic          hsync_q, vsync_q, de_q, pix_tick_q, line_start_q, frame_start_q;
    logic [CW-1:0] x_q, y_q;
    // A wrap seen on a tick is reported on the next output cycle, which shows hcnt==0
    logic          line_pend, frame_pend;

    // Prescaler, raster counters and output registers, all frozen when EN is low
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pcnt          <= '0;
            hcnt          <= '0;
            vcnt          <= '0;
            line_pend     <= 1'b0;
            frame_pend    <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            pix_tick_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (bus.EN) begin
            pcnt <= tick ? '0 : pcnt + PW'(1);
            if (tick) begin
                if (h_wrap) begin
                    hcnt <= '0;
                    vcnt <= v_wrap ? '0 : vcnt + CW'(1);
                end else begin
                    hcnt <= hcnt + CW'(1);
                end
            end
            line_pend     <= tick && h_wrap;
            frame_pend    <= tick && h_wrap && v_wrap;
            hsync_q       <= hs_act ? HS_POL : ~HS_POL;
            vsync_q       <= vs_act ? VS_POL : ~VS_POL;
            de_q          <= de;
            x_q           <= x_nxt;
            y_q           <= y_nxt;
            pix_tick_q    <= tick;
            line_start_q  <= line_pend;
            frame_start_q <= frame_pend;
        end else begin
            pix_tick_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end
    end

    assign bus.HSYNC       = hsync_q;
    assign bus.VSYNC       = vsync_q;
    assign bus.DE          = de_q;
    assign bus.X           = x_q;
    assign bus.Y           = y_q;
    assign bus.PIX_TICK    = pix_tick_q;
    assign bus.LINE_START  = line_start_q;
    assign bus.FRAME_START = frame_start_q;

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised, runtime-programmable VGA raster timing generator. It replaces fixed single-axis sync counters with one block that owns both the horizontal and vertical counters. It generates HSYNC, VSYNC, the data-enable, active-area pixel coordinates and line/frame strobes. It sits between the clock source and the pixel/RGB path of the VGA controller, and a built-in prescaler derives the pixel rate from CLK.

Parameters:
CW, 12, width of the H/V counters, the timing inputs and the X/Y outputs
DIV, 2, CLK cycles per pixel tick (DIV >= 1)
HS_POL, 0, HSYNC active level (0 = active-low)
VS_POL, 0, VSYNC active level (0 = active-low)

Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-low
EN  in  1  run enable; 0 freezes the prescaler, the counters and all outputs
H_SYNC_END  in  CW  first hcnt value outside the HSYNC pulse
H_ACT_START  in  CW  first active hcnt
H_ACT_END  in  CW  first hcnt after the active region
H_TOTAL  in  CW  last hcnt of a line (line length = H_TOTAL+1)
V_SYNC_END, V_ACT_START, V_ACT_END, V_TOTAL  in  CW each  vertical equivalents, in lines
HSYNC  out  1  horizontal sync
VSYNC  out  1  vertical sync
DE  out  1  active video / RGB enable
X  out  CW  active-area column
Y  out  CW  active-area row
PIX_TICK  out  1  one-CLK pixel-rate strobe
LINE_START  out  1  one-CLK pulse on the first pixel of each line
FRAME_START  out  1  one-CLK pulse on the first pixel of each frame

Behaviour:
- Prescaler: pcnt counts 0..DIV-1 while EN=1. The internal tick fires when pcnt==DIV-1; pcnt then wraps to 0. With DIV=1 the tick fires every enabled CLK.
- On each tick:
  - if hcnt >= H_TOTAL: hcnt<=0, and vcnt<=(vcnt>=V_TOTAL)?0:vcnt+1
  - else hcnt<=hcnt+1
  - The >= comparison ensures a live reduction of a TOTAL wraps on the next tick and never runs to 2^CW.
- Decode, from the current hcnt/vcnt:
  - hs_act = hcnt < H_SYNC_END
  - vs_act = vcnt < V_SYNC_END
  - de = (H_ACT_START <= hcnt < H_ACT_END) && (V_ACT_START <= vcnt < V_ACT_END)
  - An empty range (END <= START) never asserts.
- Output registers: all outputs are registered and updated every enabled CLK from the current counter state, giving a fixed 1-CLK latency from counter to pins. All outputs stay mutually aligned.
  - HSYNC = hs_act ? HS_POL : ~HS_POL
  - VSYNC = vs_act ? VS_POL : ~VS_POL
  - DE = de
  - X = de ? hcnt-H_ACT_START : 0, and Y = de ? vcnt-V_ACT_START : 0 (mod 2^CW)
  - PIX_TICK registers the tick.
  - LINE_START = 1 for exactly one CLK on the first output cycle showing hcnt==0 after a horizontal wrap.
  - FRAME_START = 1 on the first output cycle showing hcnt==0 and vcnt==0 after a vertical wrap; it coincides with LINE_START.
- Reset (RST=0, async), effective immediately:
  - pcnt=0, hcnt=0, vcnt=0
  - HSYNC=~HS_POL, VSYNC=~VS_POL (inactive)
  - DE=0, X=0, Y=0, PIX_TICK=0, LINE_START=0, FRAME_START=0
- After reset release: the first enabled CLK loads outputs from hcnt=vcnt=0. LINE_START and FRAME_START do not pulse at that point, because no wrap has occurred.
- Reset mid-frame aborts the frame; the counters restart from 0, and no partial-frame strobes are produced.
- EN=0: no prescaler, counter or output update. Outputs hold their last values, and single-cycle strobes drop to 0.
- Degenerate timing:
  - H_TOTAL=0 gives hcnt=0 always; vcnt advances every tick, and LINE_START pulses every tick.
  - V_TOTAL=0 gives vcnt=0 always; every line wrap is also a frame wrap.
- Timing inputs are sampled live every cycle unless VGA_SHADOW_EN is defined.

Optional Feature:
Macro VGA_SHADOW_EN.
- Defined: all eight timing inputs are captured into shadow registers at reset release (the first CLK after RST rises). They are then re-captured only on the tick that wraps both counters to 0, i.e. at the frame boundary. Decode and wrap logic use only the shadow copies, so mid-frame input changes take effect from the next frame and never tear a frame. Shadows reset to 0.
- Not defined: no shadow registers; the inputs are used directly and changes take effect on the next tick.

Test Plan:
1. Reset values: hold RST=0 with HS_POL=VS_POL=0 -> HSYNC=1, VSYNC=1, DE=0, X=Y=0, all strobes 0; assert RST asynchronously mid-line -> outputs return to these values before the next CLK edge.
2. Horizontal timing: DIV=1, H=(2,4,12,15), V=(1,2,6,7) -> HSYNC low for 2 of every 16 CLKs, line period 16 CLKs, DE high for 8 CLKs on lines 2..5 with X=0..7, Y=0..3, VSYNC low on line 0 only, frame = 128 CLKs, FRAME_START every 128 CLKs.
3. Prescaler: DIV=4 with the same timing -> PIX_TICK every 4th CLK, each X value held for 4 CLKs, frame = 512 CLKs.
4. EN gating: drop EN for 10 CLKs during DE at X=3 -> X stays at 3, no strobes, line resumes and completes with total period 16+10 CLKs.
5. Live total change: H_TOTAL 15 -> 5 while hcnt=9 -> wrap on the next tick, LINE_START pulse, subsequent lines 6 pixels. With VGA_SHADOW_EN defined, 16-pixel lines continue until the FRAME_START pulse, then 6-pixel lines.
6. Degenerate ranges: H_ACT_END=H_ACT_START=4 -> DE never asserts for a full frame; H_TOTAL=0 -> LINE_START every tick.
